// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: per-slot price/stock register file and a
// one-purchase-at-a-time FSM that vends with change or refunds on cancel/timeout.
module vend_ctrl_param #(
  parameter int ITEMS   = 64,
  parameter int ITEM_W  = 6,
  parameter int PRICE_W = 16,
  parameter int NOTE_W  = 7,
  parameter int STOCK_W = 7,
  parameter int TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [31:0]        paddr,
  input  logic               pwrite,
  input  logic               psel,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  input  logic               item_valid,
  input  logic [ITEM_W-1:0]  item_code,
  input  logic               i_valid,
  input  logic [NOTE_W-1:0]  note_val,
  input  logic               cancel,
  output logic               o_valid,
  output logic [ITEM_W-1:0]  output_item,
  output logic [PRICE_W-1:0] note_change,
  output logic               o_refund,
  output logic               o_reject,
  output logic               busy
);

  localparam int ACC_W = PRICE_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_VEND,
    S_REFUND
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic [PRICE_W-1:0] r_price [ITEMS];
  logic [STOCK_W-1:0] r_stock [ITEMS];
  logic [31:0]        r_sales;
  logic [31:0]        r_prdata;

  logic [ITEM_W-1:0]  r_code;
  logic [PRICE_W-1:0] r_lockPrice;
  logic [ACC_W-1:0]   r_acc;
  logic [TMR_W-1:0]   r_timer;
  logic [PRICE_W-1:0] r_change;
  logic               r_reject;

  logic               w_codeInRange;
  logic               w_selOk;
  logic [PRICE_W-1:0] w_selPrice;
  logic [STOCK_W-1:0] w_selStock;
  logic               w_wrEn;
  logic               w_rdEn;
  logic               w_addrInRange;
  logic [ITEM_W-1:0]  w_regIdx;
  logic [31:0]        w_rdWord;
  logic [ACC_W-1:0]   w_accN;
  logic               w_vend;
  logic               w_unused;

  logic               w_accept;
  logic               w_reject;
  logic               w_loadAcc;
  logic               w_timerInc;
  logic               w_setChg;
  logic [PRICE_W-1:0] w_chgVal;

  // When the code width cannot express an out-of-range slot the check folds away.
  if (ITEMS >= (1 << ITEM_W)) begin : g_fullRange
    assign w_codeInRange = 1'b1;
  end else begin : g_partRange
    assign w_codeInRange = (32'(item_code) < 32'(ITEMS));
  end

  assign w_selPrice    = r_price[item_code];
  assign w_selStock    = r_stock[item_code];
  assign w_selOk       = w_codeInRange && (w_selStock != '0) && (w_selPrice != '0);

  assign w_addrInRange = (paddr < 32'(ITEMS));
  assign w_regIdx      = paddr[ITEM_W-1:0];
  assign w_wrEn        = psel & pwrite & w_addrInRange;
  assign w_rdEn        = psel & ~pwrite;
  assign w_rdWord      = (32'(r_stock[w_regIdx]) << 16) | 32'(r_price[w_regIdx]);

  assign w_accN        = r_acc + ACC_W'(note_val);
  assign w_vend        = (r_state == S_VEND);
  assign w_unused      = ^pwdata;

  // A register write to the vending slot overrides that cycle's stock decrement.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ITEMS; i++) begin
        r_price[i] <= '0;
        r_stock[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ITEMS; i++) begin
        if (w_wrEn && (w_regIdx == ITEM_W'(i))) begin
          r_price[i] <= pwdata[PRICE_W-1:0];
          r_stock[i] <= pwdata[16+STOCK_W-1:16];
        end else if (w_vend && (r_code == ITEM_W'(i)) && (r_stock[i] != '0)) begin
          r_stock[i] <= r_stock[i] - STOCK_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prdata <= '0;
      r_sales  <= '0;
    end else begin
      if (w_rdEn) begin
        if (w_addrInRange)
          r_prdata <= w_rdWord;
        else if (paddr == 32'(ITEMS))
          r_prdata <= r_sales;
        else
          r_prdata <= '0;
      end
      if (w_vend && (r_sales != '1))
        r_sales <= r_sales + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_state <= S_IDLE;
    else
      r_state <= w_nextState;
  end

  // Cancel beats a price-meeting note; a note beats the timeout in the same cycle.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_loadAcc   = 1'b0;
    w_timerInc  = 1'b0;
    w_setChg    = 1'b0;
    w_chgVal    = '0;
    case (r_state)
      S_IDLE: begin
        if (item_valid) begin
          if (w_selOk) begin
            w_accept    = 1'b1;
            w_nextState = S_COLLECT;
          end else begin
            w_reject    = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (i_valid) begin
          if (cancel) begin
            w_nextState = S_REFUND;
            w_setChg    = 1'b1;
            w_chgVal    = PRICE_W'(w_accN);
          end else if (w_accN >= ACC_W'(r_lockPrice)) begin
            w_nextState = S_VEND;
            w_setChg    = 1'b1;
            w_chgVal    = PRICE_W'(w_accN - ACC_W'(r_lockPrice));
          end else begin
            w_loadAcc   = 1'b1;
          end
        end else if (cancel || (r_timer == TMR_W'(TIMEOUT - 1))) begin
          w_nextState = S_REFUND;
          w_setChg    = 1'b1;
          w_chgVal    = PRICE_W'(r_acc);
        end else begin
          w_timerInc  = 1'b1;
        end
      end
      S_VEND:   w_nextState = S_IDLE;
      S_REFUND: w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_code      <= '0;
      r_lockPrice <= '0;
      r_acc       <= '0;
      r_timer     <= '0;
      r_change    <= '0;
      r_reject    <= 1'b0;
    end else begin
      r_reject <= w_reject;
      if (w_accept) begin
        r_code      <= item_code;
        r_lockPrice <= w_selPrice;
        r_acc       <= '0;
        r_timer     <= '0;
      end
      if (w_loadAcc) begin
        r_acc   <= w_accN;
        r_timer <= '0;
      end
      if (w_timerInc)
        r_timer <= r_timer + TMR_W'(1);
      if (w_setChg)
        r_change <= w_chgVal;
    end
  end

  assign prdata      = r_prdata;
  assign o_valid     = (r_state == S_VEND);
  assign o_refund    = (r_state == S_REFUND);
  assign busy        = (r_state != S_IDLE);
  assign o_reject    = r_reject;
  assign output_item = r_code;
  assign note_change = r_change;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Self-checking bench for vend_ctrl_param: directed purchase scenarios followed by
// randomized purchases checked against a slot/price/stock arithmetic model.
module tb_vend_ctrl_param;

  localparam int ITEMS   = 40;
  localparam int ITEM_W  = 6;
  localparam int PRICE_W = 16;
  localparam int NOTE_W  = 7;
  localparam int STOCK_W = 7;
  localparam int TIMEOUT = 24;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [31:0]        paddr = '0;
  logic               pwrite = 1'b0;
  logic               psel = 1'b0;
  logic [31:0]        pwdata = '0;
  logic [31:0]        prdata;
  logic               item_valid = 1'b0;
  logic [ITEM_W-1:0]  item_code = '0;
  logic               i_valid = 1'b0;
  logic [NOTE_W-1:0]  note_val = '0;
  logic               cancel = 1'b0;
  logic               o_valid;
  logic [ITEM_W-1:0]  output_item;
  logic [PRICE_W-1:0] note_change;
  logic               o_refund;
  logic               o_reject;
  logic               busy;

  vend_ctrl_param #(
    .ITEMS(ITEMS), .ITEM_W(ITEM_W), .PRICE_W(PRICE_W),
    .NOTE_W(NOTE_W), .STOCK_W(STOCK_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn), .paddr(paddr), .pwrite(pwrite), .psel(psel),
    .pwdata(pwdata), .prdata(prdata), .item_valid(item_valid),
    .item_code(item_code), .i_valid(i_valid), .note_val(note_val),
    .cancel(cancel), .o_valid(o_valid), .output_item(output_item),
    .note_change(note_change), .o_refund(o_refund), .o_reject(o_reject),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  int mPrice [ITEMS];
  int mStock [ITEMS];
  int mSales;
  int mChange;

  int qNote [8];
  int qGap  [8];
  int qLen;
  int qCancelAt;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp)
      nPass++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input int code, input logic nv,
                               input int note, input logic can);
    item_valid = iv;
    item_code  = ITEM_W'(code);
    i_valid    = nv;
    note_val   = NOTE_W'(note);
    cancel     = can;
    tick();
    item_valid = 1'b0;
    item_code  = '0;
    i_valid    = 1'b0;
    note_val   = '0;
    cancel     = 1'b0;
  endtask

  task automatic modelClear();
    for (int i = 0; i < ITEMS; i++) begin
      mPrice[i] = 0;
      mStock[i] = 0;
    end
    mSales  = 0;
    mChange = 0;
  endtask

  task automatic regWrite(input int addr, input int price, input int stock);
    psel   = 1'b1;
    pwrite = 1'b1;
    paddr  = 32'(addr);
    pwdata = (32'(stock) << 16) | 32'(price);
    if (addr < ITEMS) begin
      mPrice[addr] = price;
      mStock[addr] = stock;
    end
    tick();
    psel   = 1'b0;
    pwrite = 1'b0;
  endtask

  task automatic regRead(input int addr, output logic [31:0] data);
    psel   = 1'b1;
    pwrite = 1'b0;
    paddr  = 32'(addr);
    tick();
    data   = prdata;
    psel   = 1'b0;
  endtask

  function automatic logic [31:0] slotWord(input int idx);
    return (32'(mStock[idx]) << 16) | 32'(mPrice[idx]);
  endfunction

  // Runs one customer interaction using qNote/qGap/qLen/qCancelAt; qCancelAt == qLen
  // means a bare cancel after the notes, -1 means wait for the inactivity refund.
  task automatic runPurchase(input int code);
    bit ok;
    bit done;
    int paid;
    int price;
    int seen;
    ok = (code < ITEMS) && (mStock[code] > 0) && (mPrice[code] > 0);
    applyStimulus(1'b1, code, 1'b0, 0, 1'b0);
    if (!ok) begin
      checkOutput("reject pulse", o_reject, 1);
      checkOutput("reject busy", busy, 0);
      checkOutput("reject no vend", o_valid, 0);
      applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
      checkOutput("reject single", o_reject, 0);
      return;
    end
    checkOutput("select busy", busy, 1);
    checkOutput("select no reject", o_reject, 0);
    price = mPrice[code];
    paid  = 0;
    done  = 0;
    for (int k = 0; k < qLen && !done; k++) begin
      for (int g = 0; g < qGap[k]; g++) begin
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
        checkOutput("gap no refund", o_refund, 0);
      end
      paid += qNote[k];
      applyStimulus(1'b0, 0, 1'b1, qNote[k], qCancelAt == k);
      if (qCancelAt == k) begin
        mChange = paid;
        checkOutput("cancel refund", o_refund, 1);
        checkOutput("cancel no vend", o_valid, 0);
        checkOutput("cancel amount", 32'(note_change), 32'(mChange));
        done = 1;
      end else if (paid >= price) begin
        mChange = paid - price;
        mStock[code]--;
        mSales++;
        checkOutput("vend pulse", o_valid, 1);
        checkOutput("vend item", 32'(output_item), 32'(code));
        checkOutput("vend change", 32'(note_change), 32'(mChange));
        done = 1;
      end else begin
        checkOutput("collect no vend", o_valid, 0);
        checkOutput("collect no refund", o_refund, 0);
      end
    end
    if (!done && qCancelAt == qLen) begin
      applyStimulus(1'b0, 0, 1'b0, 0, 1'b1);
      mChange = paid;
      checkOutput("bare cancel refund", o_refund, 1);
      checkOutput("bare cancel amount", 32'(note_change), 32'(mChange));
      done = 1;
    end
    if (!done) begin
      seen = -1;
      for (int k = 1; k <= TIMEOUT + 4; k++) begin
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
        if (o_refund) begin
          seen = k;
          break;
        end
      end
      mChange = paid;
      checkOutput("timeout cycles", 32'(seen), 32'(TIMEOUT));
      checkOutput("timeout amount", 32'(note_change), 32'(mChange));
    end
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    checkOutput("back idle busy", busy, 0);
    checkOutput("back idle no vend", o_valid, 0);
    checkOutput("change holds", 32'(note_change), 32'(mChange));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int code;
    modelClear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst busy", busy, 0);
    checkOutput("rst o_valid", o_valid, 0);
    checkOutput("rst o_refund", o_refund, 0);
    checkOutput("rst o_reject", o_reject, 0);
    checkOutput("rst output_item", 32'(output_item), 0);
    checkOutput("rst note_change", 32'(note_change), 0);
    checkOutput("rst prdata", prdata, 0);
    rstn = 1'b1;
    tick();

    $display("[TB] register programming");
    regWrite(1, 150, 100);
    regRead(1, rd);
    checkOutput("rd slot1", rd, (32'd100 << 16) | 32'd150);
    regRead(ITEMS, rd);
    checkOutput("rd sales init", rd, 0);

    $display("[TB] basic vend with change");
    qNote[0] = 100; qNote[1] = 100; qGap[0] = 0; qGap[1] = 0; qLen = 2; qCancelAt = -1;
    runPurchase(1);
    regRead(1, rd);
    checkOutput("rd slot1 after vend", rd, slotWord(1));
    regRead(ITEMS, rd);
    checkOutput("rd sales after vend", rd, 32'(mSales));

    $display("[TB] rejections");
    runPurchase(5);
    runPurchase(ITEMS + 3);

    $display("[TB] cancel refunds");
    qNote[0] = 100; qLen = 1; qCancelAt = 1;
    runPurchase(1);
    qNote[0] = 100; qNote[1] = 100; qLen = 2; qCancelAt = 1;
    runPurchase(1);
    regRead(1, rd);
    checkOutput("rd slot1 after cancels", rd, slotWord(1));

    $display("[TB] inactivity timeout");
    qNote[0] = 50; qGap[0] = 0; qLen = 1; qCancelAt = -1;
    runPurchase(1);

    $display("[TB] reset mid-purchase");
    applyStimulus(1'b1, 1, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 30, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst o_refund", o_refund, 0);
    checkOutput("midrst o_valid", o_valid, 0);
    checkOutput("midrst note_change", 32'(note_change), 0);
    checkOutput("midrst prdata", prdata, 0);
    tick();
    checkOutput("midrst still no refund", o_refund, 0);
    rstn = 1'b1;
    modelClear();
    tick();
    regRead(1, rd);
    checkOutput("rd slot1 cleared", rd, 0);
    regWrite(2, 10, 1);
    qNote[0] = 10; qGap[0] = 0; qLen = 1; qCancelAt = -1;
    runPurchase(2);
    runPurchase(2);

    $display("[TB] out-of-range register access");
    regWrite(ITEMS + 1, 77, 3);
    regRead(ITEMS + 1, rd);
    checkOutput("rd oob", rd, 0);

    $display("[TB] randomized purchases");
    for (int s = 0; s < 10; s++)
      regWrite(s, ($urandom % 6 == 0) ? 0 : int'($urandom_range(1, 250)), int'($urandom_range(0, 3)));
    for (int t = 0; t < 40; t++) begin
      if ($urandom % 5 == 0) begin
        code = int'($urandom_range(0, 9));
        regWrite(code, int'($urandom_range(1, 250)), int'($urandom_range(0, 3)));
      end
      code = ($urandom % 8 == 0) ? ITEMS + int'($urandom % 20) : int'($urandom % 10);
      qLen = int'($urandom_range(0, 6));
      for (int k = 0; k < qLen; k++) begin
        qNote[k] = int'($urandom_range(1, 127));
        qGap[k]  = ($urandom % 3 == 0) ? int'($urandom_range(0, TIMEOUT - 3)) : 0;
      end
      qCancelAt = ($urandom % 4 == 0) ? int'($urandom_range(0, qLen)) : -1;
      runPurchase(code);
      repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    end
    for (int s = 0; s < 12; s++) begin
      regRead(s, rd);
      checkOutput("rd slot final", rd, slotWord(s));
    end
    regRead(ITEMS, rd);
    checkOutput("rd sales final", rd, 32'(mSales));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/vend_ctrl_param.md
# vend_ctrl_param

Parametrised vending controller: the next generation of the single-item vending core. A register port on the same clock programs a price and stock count per item slot. The control FSM then handles one purchase at a time:

- accepts an item selection,
- accumulates inserted note values,
- dispenses with change once the price is met,
- refunds on cancel or inactivity timeout.

It sits between the coin/note front end and the dispenser/cash-return actuators.

## Interface
Parameters:
- ITEMS, 64, number of item slots (addresses 0..ITEMS-1)
- ITEM_W, 6, item code width, must be ≥ clog2(ITEMS)
- PRICE_W, 16, price width and note_change width
- NOTE_W, 7, note value width
- STOCK_W, 7, per-item stock count width
- TIMEOUT, 1000, idle cycles in COLLECT before auto-refund

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- paddr  in  32  register address
- pwrite  in  1  1 = write, 0 = read
- psel  in  1  register access strobe
- pwdata  in  32  write data: [PRICE_W-1:0] price, [16+STOCK_W-1:16] stock
- prdata  out  32  read data, registered
- item_valid  in  1  item selection strobe
- item_code  in  ITEM_W  selected slot
- i_valid  in  1  note inserted strobe
- note_val  in  NOTE_W  value of inserted note
- cancel  in  1  customer cancel request
- o_valid  out  1  one-cycle dispense pulse
- output_item  out  ITEM_W  dispensed slot, valid with o_valid
- note_change  out  PRICE_W  change (with o_valid) or refund amount (with o_refund)
- o_refund  out  1  one-cycle refund pulse
- o_reject  out  1  one-cycle pulse: selection refused
- busy  out  1  high while FSM not IDLE

## Operation
- Register file: ITEMS entries, each holding price[PRICE_W] and stock[STOCK_W]. Reset value of every entry is 0.
- Write: psel & pwrite & paddr < ITEMS updates the entry at that edge.
- Read address ITEMS returns a 32-bit saturating sales counter (count of successful vends). All other out-of-range addresses read 0 and ignore writes.
- Accumulator acc is PRICE_W+1 bits wide. It never overflows, since acc ≤ price-1 + 2^NOTE_W-1.
- States:
  - IDLE:
    - item_valid with item_code < ITEMS, stock ≠ 0 and price ≠ 0: latch code and price, acc ← 0, go to COLLECT.
    - Any other item_valid: o_reject pulse, stay in IDLE.
    - i_valid and cancel are ignored.
  - COLLECT:
    - On i_valid, acc_n = acc + note_val.
    - If acc_n ≥ price: go to VEND; note_change ← acc_n − price.
    - Otherwise acc ← acc_n, timer ← 0.
    - Without i_valid, timer increments. Timer reaching TIMEOUT−1, or cancel, goes to REFUND with note_change ← acc.
    - cancel with i_valid in the same cycle: the note is added first, then REFUND with the new acc. Refund wins even if the price is met.
    - item_valid is ignored.
  - VEND (one cycle):
    - o_valid=1 and output_item=latched code.
    - Stock of that slot decrements; the sales counter increments.
    - Returns to IDLE.
  - REFUND (one cycle): o_refund=1, returns to IDLE.
- Stock decrement in VEND and a register write to the same slot in the same cycle: the register write wins.
- Price changes during COLLECT do not affect the latched price.

## Timing
- Reset values:
  - FSM = IDLE, busy=0.
  - o_valid=0, o_refund=0, o_reject=0.
  - output_item=0, note_change=0, prdata=0.
  - acc=0, timer=0, sales counter 0.
- Reset asserted mid-purchase: the FSM drops to IDLE immediately. The accumulated amount is lost and no refund pulse is issued.
- prdata: a read sampled at edge N is valid after edge N and holds until the next read.
- Selection at edge N: busy=1 from edge N. o_reject (if refused) is high for the cycle after edge N.
- Payment-completing note at edge N: o_valid and note_change are high/valid for the cycle after edge N. busy falls at edge N+1.
- note_change holds its value until the next VEND or REFUND.
- Timeout: with no note since edge N, REFUND is entered at edge N+TIMEOUT.
- Back-to-back purchases: a new item_valid is accepted in the first IDLE cycle.

## Test plan
- Write slot 1 price=150, stock=100. Read back slot 1 -> prdata = {stock 100, price 150}. Read address ITEMS -> 0.
- Select item 1; insert notes 100 then 100 -> one o_valid, output_item=1, note_change=50. Slot 1 stock reads 99; sales counter reads 1.
- Select a slot with stock=0, and separately item_code ≥ ITEMS -> o_reject single pulse, busy stays 0, no o_valid.
- Select item 1, insert 100, assert cancel -> o_refund, note_change=100, stock unchanged. Repeat with cancel coincident with a second note of 100 -> refund 200.
- Select item 1, insert 50, wait TIMEOUT cycles -> o_refund with note_change=50, exactly TIMEOUT cycles after that note.
- Assert rstn low in COLLECT after one note -> all outputs 0, FSM IDLE, register file cleared. Then write slot 2 price=10, stock=1 and buy it twice: first buy -> o_valid; second select -> o_reject.
